// File: rtl/hex_keypad_pkg.sv
// hex_keypad_pkg -- shared types and constants for the hex keypad scanner.
//   scan_state_t   : debounce state machine states
//   frame_kind_t   : classification of one full 4x4 scan frame
//   frame_class_t  : frame kind plus the key code of a single-key frame
//   classify_frame : turns 16 matrix bits (index = row*4 + col) into a frame_class_t
package hex_keypad_pkg;

    localparam int KEY_CODE_W  = 4;
    localparam int NUM_COLS    = 4;
    localparam int NUM_ROWS    = 4;
    localparam int DWELL_TICKS = 4;
    localparam int NUM_KEYS    = NUM_ROWS * NUM_COLS;
    localparam int FIFO_DEPTH  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } scan_state_t;

    typedef enum logic [1:0] {
        FRAME_EMPTY,
        FRAME_SINGLE,
        FRAME_MULTI
    } frame_kind_t;

    typedef struct packed {
        frame_kind_t                 kind;
        logic [KEY_CODE_W-1:0]       code;
    } frame_class_t;

    // Bit index of the matrix equals the key code {row[1:0], col[1:0]}, so the
    // code of a single-key frame is just the index of its only set bit.
    function automatic frame_class_t classify_frame(input logic [NUM_KEYS-1:0] bits);
        frame_class_t res;
        int           n_set;
        res.kind = FRAME_EMPTY;
        res.code = '0;
        n_set    = 0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (bits[i]) begin
                n_set++;
                res.code = KEY_CODE_W'(i);
            end
        end
        if (n_set == 1)
            res.kind = FRAME_SINGLE;
        else if (n_set > 1)
            res.kind = FRAME_MULTI;
        return res;
    endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// keypad_event_fifo -- 4-entry event queue between the debouncer and consumer.
//   clk, reset_n : clock, asynchronous active-low reset
//   push         : enqueue push_code this cycle
//   push_code    : key code to enqueue
//   pop          : consumer took the head entry this cycle
//   head_valid   : queue is not empty
//   head_code    : oldest queued key code
//   drop         : push refused because the queue is full and nothing popped
module keypad_event_fifo
    import hex_keypad_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [KEY_CODE_W-1:0] push_code,
    input  logic                  pop,
    output logic                  head_valid,
    output logic [KEY_CODE_W-1:0] head_code,
    output logic                  drop
);

    logic [KEY_CODE_W-1:0] mem [FIFO_DEPTH];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [2:0]            count;
    logic                  do_pop;
    logic                  accept;

    // A slot freed by a pop in the same cycle is usable by the push.
    assign do_pop     = pop && (count != 3'd0);
    assign accept     = push && ((count != 3'(FIFO_DEPTH)) || do_pop);
    assign drop       = push && !accept;
    assign head_valid = (count != 3'd0);
    assign head_code  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the storage is tiny and key_code must read 0 out of reset,
            // so the array is reset here; larger memories normally are not.
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= push_code;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 2'd1;
            case ({accept, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner -- scans a 4x4 keypad, debounces whole frames and
// delivers one event per accepted key press over a valid/ready handshake.
//   clk, reset_n : clock, asynchronous active-low reset
//   col_drive    : one-hot column strobe, active-high
//   row_sense    : asynchronous row returns, active-high
//   key_code     : {row[1:0], col[1:0]} of the event at the head of storage
//   key_valid    : key_code holds an undelivered event
//   key_ready    : consumer accepts (transfer on key_valid & key_ready)
//   key_held     : a key is currently considered pressed (PRESSED/RELEASE)
//   key_overrun  : sticky, an event was lost for lack of storage
//   overrun_clr  : synchronous clear of key_overrun
// Build option: define KEYPAD_FIFO_EN for a 4-entry event FIFO; otherwise a
// single holding register keeps the first undelivered event.
module hex_keypad_scanner
    import hex_keypad_pkg::*;
#(
    parameter int CLK_RATE_HZ     = 390625,
    parameter int CLK_DIVIDE      = 1,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [NUM_COLS-1:0]   col_drive,
    input  logic [NUM_ROWS-1:0]   row_sense,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    input  logic                  key_ready,
    output logic                  key_held,
    output logic                  key_overrun,
    input  logic                  overrun_clr
);

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_FRAMES);

    logic [NUM_ROWS-1:0] row_meta, row_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_meta <= '0;
            row_sync <= '0;
        end else begin
            // NOTE: non-blocking assignments so row_sync takes the old row_meta
            // and the two flops form a real two-stage synchronizer.
            row_meta <= row_sense;
            row_sync <= row_meta;
        end
    end

    logic scan_tick;

    generate
        if (CLK_DIVIDE != 0) begin : g_div
            localparam int DIV   = (CLK_RATE_HZ / 3200 > 1) ? CLK_RATE_HZ / 3200 : 1;
            localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
            logic [DIV_W-1:0] div_cnt;

            assign scan_tick = (div_cnt == DIV_W'(DIV - 1));

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    div_cnt <= '0;
                else if (scan_tick)
                    div_cnt <= '0;
                else
                    div_cnt <= div_cnt + DIV_W'(1);
            end
        end else begin : g_nodiv
            assign scan_tick = 1'b1;
        end
    endgenerate

    // Column scan: each column is driven for DWELL_TICKS ticks and sampled on
    // the last one. Column 3 is not stored; its rows are used live at frame close.
    logic [1:0]          col_idx, dwell;
    logic [NUM_ROWS-1:0] rows_c0, rows_c1, rows_c2;
    logic                sample_tick, frame_close;

    assign sample_tick = scan_tick && (dwell == 2'(DWELL_TICKS - 1));
    assign frame_close = sample_tick && (col_idx == 2'(NUM_COLS - 1));
    assign col_drive   = 4'b0001 << col_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_idx <= '0;
            dwell   <= '0;
            rows_c0 <= '0;
            rows_c1 <= '0;
            rows_c2 <= '0;
        end else if (scan_tick) begin
            if (sample_tick) begin
                case (col_idx)
                    2'd0:    rows_c0 <= row_sync;
                    2'd1:    rows_c1 <= row_sync;
                    2'd2:    rows_c2 <= row_sync;
                    default: ;
                endcase
                dwell   <= '0;
                col_idx <= col_idx + 2'd1;
            end else begin
                dwell <= dwell + 2'd1;
            end
        end
    end

    logic [NUM_KEYS-1:0] frame_bits;
    frame_class_t        fc;

    always_comb begin
        frame_bits = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            frame_bits[r*NUM_COLS + 0] = rows_c0[r];
            frame_bits[r*NUM_COLS + 1] = rows_c1[r];
            frame_bits[r*NUM_COLS + 2] = rows_c2[r];
            frame_bits[r*NUM_COLS + 3] = row_sync[r];
        end
    end

    assign fc = classify_frame(frame_bits);

    scan_state_t           state, state_nxt;
    logic [KEY_CODE_W-1:0] cand, cand_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic                  push;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cand  <= cand_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        push      = 1'b0;
        if (frame_close) begin
            case (state)
                ST_IDLE: begin
                    if (fc.kind == FRAME_SINGLE) begin
                        state_nxt = ST_DEBOUNCE;
                        cand_nxt  = fc.code;
                        cnt_nxt   = 4'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (fc.kind == FRAME_SINGLE) begin
                        if (fc.code == cand) begin
                            if (cnt + 4'd1 == DB_LAST) begin
                                push      = 1'b1;
                                state_nxt = ST_PRESSED;
                                cnt_nxt   = '0;
                            end else begin
                                cnt_nxt = cnt + 4'd1;
                            end
                        end else begin
                            cand_nxt = fc.code;
                            cnt_nxt  = 4'd1;
                        end
                    end else begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end
                end
                ST_PRESSED: begin
                    // Additional or changed keys while held produce nothing.
                    if (fc.kind == FRAME_EMPTY) begin
                        state_nxt = ST_RELEASE;
                        cnt_nxt   = 4'd1;
                    end
                end
                ST_RELEASE: begin
                    if (fc.kind == FRAME_EMPTY) begin
                        if (cnt + 4'd1 == DB_LAST) begin
                            state_nxt = ST_IDLE;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + 4'd1;
                        end
                    end else begin
                        state_nxt = ST_PRESSED;
                        cnt_nxt   = '0;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign key_held = (state == ST_PRESSED) || (state == ST_RELEASE);

    logic pop, drop;
    assign pop = key_valid && key_ready;

`ifdef KEYPAD_FIFO_EN
    keypad_event_fifo u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_code  (cand),
        .pop        (pop),
        .head_valid (key_valid),
        .head_code  (key_code),
        .drop       (drop)
    );
`else
    // Single holding register: the first undelivered event is kept and later
    // pushes are dropped, unless the register is being emptied this cycle.
    assign drop = push && key_valid && !pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_valid <= 1'b0;
            key_code  <= '0;
        end else if (push && (!key_valid || pop)) begin
            key_valid <= 1'b1;
            key_code  <= cand;
        end else if (pop) begin
            key_valid <= 1'b0;
        end
    end
`endif

    // A drop in the same cycle as overrun_clr leaves the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            key_overrun <= 1'b0;
        else if (drop)
            key_overrun <= 1'b1;
        else if (overrun_clr)
            key_overrun <= 1'b0;
    end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// tb_hex_keypad_scanner -- directed bench for hex_keypad_scanner with
// CLK_DIVIDE=0 and DEBOUNCE_FRAMES=4 (one frame = 16 clk). A behavioural
// keypad turns the pressed-key set and col_drive into row_sense.
// Build option: KEYPAD_FIFO_EN selects the FIFO expectations.
module tb_hex_keypad_scanner;

`ifdef KEYPAD_FIFO_EN
    localparam int EXP_DEPTH = 4;
`else
    localparam int EXP_DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] col_drive;
    logic [3:0] row_sense;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready = 1'b0;
    logic       key_held;
    logic       key_overrun;
    logic       overrun_clr = 1'b0;

    logic [15:0] keys = '0;
    logic [3:0]  xfer_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    hex_keypad_scanner #(
        .CLK_RATE_HZ     (390625),
        .CLK_DIVIDE      (0),
        .DEBOUNCE_FRAMES (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .col_drive   (col_drive),
        .row_sense   (row_sense),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_held    (key_held),
        .key_overrun (key_overrun),
        .overrun_clr (overrun_clr)
    );

    // Keypad: a closed key at (r, c) pulls row r high while column c is strobed.
    always_comb begin
        row_sense = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4 + c] && col_drive[c])
                    row_sense[r] = 1'b1;
    end

    always @(posedge clk)
        if (reset_n && key_valid && key_ready)
            xfer_q.push_back(key_code);

    // Returns on the falling edge right after a frame close (col 3 -> col 0).
    task automatic wait_frame();
        logic [3:0] prev;
        prev = col_drive;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (prev == 4'b1000 && col_drive == 4'b0001)
                return;
            prev = col_drive;
        end
        checks++;
        errors++;
        $display("FAIL frame_timeout col_drive=%b never wrapped 1000->0001 within 40 clk", col_drive);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (col_drive !== 4'b0001) begin errors++; $display("FAIL reset_col got %b want 0001", col_drive); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", key_valid); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code got %h want 0", key_code); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held got %b want 0", key_held); end
        checks++; if (key_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", key_overrun); end
        reset_n = 1'b1;
        wait_frame();
    endtask

    task automatic test_single_press();
        key_ready = 1'b1;
        xfer_q.delete();
        keys = 16'h0200;
        for (int f = 1; f <= 10; f++) begin
            wait_frame();
            if (f < 4) begin
                checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL press_early_valid frame %0d got %b want 0", f, key_valid); end
                checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL press_early_held frame %0d got %b want 0", f, key_held); end
            end else if (f == 4) begin
                checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL press_valid got %b want 1", key_valid); end
                checks++; if (key_code !== 4'h9) begin errors++; $display("FAIL press_code got %h want 9", key_code); end
                checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held got %b want 1", key_held); end
            end else begin
                checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_hold frame %0d got %b want 1", f, key_held); end
            end
        end
        keys = '0;
        for (int f = 1; f <= 4; f++) begin
            wait_frame();
            checks++;
            if (key_held !== (f < 4)) begin errors++; $display("FAIL release_held frame %0d got %b want %b", f, key_held, (f < 4)); end
        end
        checks++; if (xfer_q.size() != 1) begin errors++; $display("FAIL press_xfer_count got %0d want 1", xfer_q.size()); end
        if (xfer_q.size() >= 1) begin
            checks++; if (xfer_q[0] !== 4'h9) begin errors++; $display("FAIL press_xfer_code got %h want 9", xfer_q[0]); end
        end
    endtask

    task automatic test_bounce();
        xfer_q.delete();
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
            wait_frame();
            checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL bounce_valid step %0d got %b want 0", i, key_valid); end
        end
        keys = 16'h0200;
        for (int f = 1; f <= 4; f++) begin
            wait_frame();
            checks++;
            if (key_valid !== (f == 4)) begin errors++; $display("FAIL bounce_steady_valid frame %0d got %b want %b", f, key_valid, (f == 4)); end
        end
        keys = '0;
        repeat (4) wait_frame();
        checks++; if (xfer_q.size() != 1) begin errors++; $display("FAIL bounce_xfer_count got %0d want 1", xfer_q.size()); end
        if (xfer_q.size() >= 1) begin
            checks++; if (xfer_q[0] !== 4'h9) begin errors++; $display("FAIL bounce_xfer_code got %h want 9", xfer_q[0]); end
        end
    endtask

    task automatic test_multi();
        xfer_q.delete();
        keys = 16'h0011;
        for (int f = 1; f <= 8; f++) begin
            wait_frame();
            checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL multi_valid frame %0d got %b want 0", f, key_valid); end
            checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL multi_held frame %0d got %b want 0", f, key_held); end
        end
        keys = '0;
        wait_frame();
        checks++; if (xfer_q.size() != 0) begin errors++; $display("FAIL multi_xfer_count got %0d want 0", xfer_q.size()); end
    endtask

    task automatic test_rearm();
        xfer_q.delete();
        keys = 16'h0200;
        repeat (4) wait_frame();
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL rearm_first_valid got %b want 1", key_valid); end
        keys = '0;
        repeat (2) wait_frame();
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL rearm_gap_held got %b want 1", key_held); end
        keys = 16'h0200;
        for (int f = 1; f <= 4; f++) begin
            wait_frame();
            checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rearm_repress_valid frame %0d got %b want 0", f, key_valid); end
        end
        keys = '0;
        repeat (4) wait_frame();
        checks++; if (xfer_q.size() != 1) begin errors++; $display("FAIL rearm_xfer_count got %0d want 1", xfer_q.size()); end
    endtask

    task automatic test_overrun();
        logic [3:0] codes [5];
        codes[0] = 4'h1; codes[1] = 4'h2; codes[2] = 4'h3; codes[3] = 4'h5; codes[4] = 4'h6;
        key_ready = 1'b0;
        xfer_q.delete();
        for (int k = 0; k < 5; k++) begin
            keys = 16'h0001 << codes[k];
            repeat (4) wait_frame();
            checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid event %0d got %b want 1", k, key_valid); end
            checks++; if (key_code !== codes[0]) begin errors++; $display("FAIL ovr_head_code event %0d got %h want %h", k, key_code, codes[0]); end
            checks++;
            if (key_overrun !== (k >= EXP_DEPTH)) begin errors++; $display("FAIL ovr_flag event %0d got %b want %b", k, key_overrun, (k >= EXP_DEPTH)); end
            keys = '0;
            repeat (4) wait_frame();
        end
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        checks++; if (key_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", key_overrun); end
        key_ready = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (xfer_q.size() != EXP_DEPTH) begin errors++; $display("FAIL ovr_drain_count got %0d want %0d", xfer_q.size(), EXP_DEPTH); end
        for (int i = 0; i < EXP_DEPTH && i < xfer_q.size(); i++) begin
            checks++; if (xfer_q[i] !== codes[i]) begin errors++; $display("FAIL ovr_drain_code %0d got %h want %h", i, xfer_q[i], codes[i]); end
        end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL ovr_drained_valid got %b want 0", key_valid); end
    endtask

    task automatic test_reset_mid();
        key_ready = 1'b1;
        xfer_q.delete();
        keys = 16'h0200;
        repeat (2) wait_frame();
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (col_drive !== 4'b0001) begin errors++; $display("FAIL mid_reset_col got %b want 0001", col_drive); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b want 0", key_valid); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL mid_reset_code got %h want 0", key_code); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL mid_reset_held got %b want 0", key_held); end
        checks++; if (key_overrun !== 1'b0) begin errors++; $display("FAIL mid_reset_overrun got %b want 0", key_overrun); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int f = 1; f <= 4; f++) begin
            wait_frame();
            checks++;
            if (key_valid !== (f == 4)) begin errors++; $display("FAIL mid_reset_valid frame %0d got %b want %b", f, key_valid, (f == 4)); end
        end
        checks++; if (key_code !== 4'h9) begin errors++; $display("FAIL mid_reset_code_after got %h want 9", key_code); end
        keys = '0;
        repeat (4) wait_frame();
        checks++; if (xfer_q.size() != 1) begin errors++; $display("FAIL mid_reset_xfer_count got %0d want 1", xfer_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_multi();
        test_rearm();
        test_overrun();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
